// File: rtl/vend_pkg.sv
// Shared definitions for the vending cart controller: one-hot state
// encodings, coin denominations and the unit-price table.
package vend_pkg;

    // One-hot controller states; the encoding is visible on state_out.
    typedef enum logic [4:0] {
        ST_IDLE    = 5'h01,
        ST_SELECT  = 5'h02,
        ST_PAYMENT = 5'h04,
        ST_CHANGE  = 5'h08,
        ST_REFUND  = 5'h10
    } state_e;

    // Coin denominations and their one-hot positions on coin_in/coin_out.
    localparam logic [5:0] COIN_VAL_1  = 6'd1;
    localparam logic [5:0] COIN_VAL_5  = 6'd5;
    localparam logic [5:0] COIN_VAL_10 = 6'd10;
    localparam logic [5:0] COIN_VAL_20 = 6'd20;
    localparam logic [5:0] COIN_VAL_50 = 6'd50;

    localparam logic [4:0] COIN_OH_1  = 5'b00001;
    localparam logic [4:0] COIN_OH_5  = 5'b00010;
    localparam logic [4:0] COIN_OH_10 = 5'b00100;
    localparam logic [4:0] COIN_OH_20 = 5'b01000;
    localparam logic [4:0] COIN_OH_50 = 5'b10000;

    // Unit price for category/item; any code outside 1..4 prices at zero.
    function automatic logic [3:0] unit_price(input logic [2:0] cat, input logic [2:0] item);
        logic [3:0] p;
        p = 4'd0;
        case ({cat, item})
            6'o11: p = 4'd3;   6'o12: p = 4'd4;   6'o13: p = 4'd6;   6'o14: p = 4'd3;
            6'o21: p = 4'd10;  6'o22: p = 4'd8;   6'o23: p = 4'd9;   6'o24: p = 4'd7;
            6'o31: p = 4'd4;   6'o32: p = 4'd6;   6'o33: p = 4'd15;  6'o34: p = 4'd8;
            6'o41: p = 4'd9;   6'o42: p = 4'd4;   6'o43: p = 4'd5;   6'o44: p = 4'd5;
            default: p = 4'd0;
        endcase
        return p;
    endfunction

    // Value of a coin pulse; zero or multi-hot patterns are worth nothing.
    function automatic logic [5:0] coin_value(input logic [4:0] coin);
        logic [5:0] v;
        v = 6'd0;
        case (coin)
            COIN_OH_1:  v = COIN_VAL_1;
            COIN_OH_5:  v = COIN_VAL_5;
            COIN_OH_10: v = COIN_VAL_10;
            COIN_OH_20: v = COIN_VAL_20;
            COIN_OH_50: v = COIN_VAL_50;
            default:    v = 6'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_cart_ctrl_if.sv
// Bundle of buttons, switches, coin lines and status outputs of the
// vending cart controller. Clock and reset are not part of the bundle.
//
// Signalling: every button and coin_in is a single-cycle pulse sampled on
// the rising clock edge; there is no back-pressure, a pulse is always
// consumed in the cycle it is seen (or deliberately ignored). coin_out is
// a single-cycle pulse per dispensed coin; all other outputs are levels.
interface vend_cart_ctrl_if #(
    parameter int CART_DEPTH = 4,
    parameter int QTY_W      = 2,
    parameter int MONEY_W    = 10
);
    localparam int CNT_W = $clog2(CART_DEPTH + 1);

    logic               sys_Goods;
    logic               sys_Confirm;
    logic               sys_Cancel;
    logic               sys_Change;
    logic [4:0]         coin_in;
    logic [2:0]         type_SW_high;
    logic [2:0]         type_SW_low;
    logic [QTY_W-1:0]   num_SW;
    logic [MONEY_W-1:0] input_money;
    logic [MONEY_W-1:0] need_money;
    logic [MONEY_W-1:0] change_money;
    logic [4:0]         state_out;
    logic [CNT_W-1:0]   cart_count;
    logic [4:0]         coin_out;
    logic               err_flag;

    modport master (
        output sys_Goods, sys_Confirm, sys_Cancel, sys_Change, coin_in,
               type_SW_high, type_SW_low, num_SW,
        input  input_money, need_money, change_money, state_out,
               cart_count, coin_out, err_flag
    );

    modport slave (
        input  sys_Goods, sys_Confirm, sys_Cancel, sys_Change, coin_in,
               type_SW_high, type_SW_low, num_SW,
        output input_money, need_money, change_money, state_out,
               cart_count, coin_out, err_flag
    );
endinterface

// File: rtl/vend_change_sel.sv
// Greedy coin selection: picks the largest denomination not exceeding the
// amount still owed. Purely combinational. Assumes MONEY_W >= 6 so that
// the largest coin is representable.
module vend_change_sel import vend_pkg::*; #(
    parameter int MONEY_W = 10
) (
    input  logic [MONEY_W-1:0] change_i,
    output logic [4:0]         coin_o,
    output logic [MONEY_W-1:0] value_o
);

    // Largest coin first; nothing is selected when nothing is owed.
    always_comb begin
        coin_o  = 5'b00000;
        value_o = '0;
        if (change_i >= MONEY_W'(COIN_VAL_50)) begin
            coin_o  = COIN_OH_50;
            value_o = MONEY_W'(COIN_VAL_50);
        end else if (change_i >= MONEY_W'(COIN_VAL_20)) begin
            coin_o  = COIN_OH_20;
            value_o = MONEY_W'(COIN_VAL_20);
        end else if (change_i >= MONEY_W'(COIN_VAL_10)) begin
            coin_o  = COIN_OH_10;
            value_o = MONEY_W'(COIN_VAL_10);
        end else if (change_i >= MONEY_W'(COIN_VAL_5)) begin
            coin_o  = COIN_OH_5;
            value_o = MONEY_W'(COIN_VAL_5);
        end else if (change_i != '0) begin
            coin_o  = COIN_OH_1;
            value_o = MONEY_W'(COIN_VAL_1);
        end
    end

endmodule

// File: rtl/vend_cart_ctrl.sv
// Vending cart controller: item selection into a LIFO cart, coin payment
// with saturating credit, and greedy change/refund dispensing.
// Optional feature macro VEND_AUTO_CHANGE_EN: when defined, change is paid
// out one coin per cycle without sys_Change and the controller returns to
// IDLE on its own once nothing is owed.
module vend_cart_ctrl import vend_pkg::*; #(
    parameter int CART_DEPTH = 4,
    parameter int QTY_W      = 2,
    parameter int MONEY_W    = 10
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    vend_cart_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(CART_DEPTH + 1);
    localparam logic [CNT_W-1:0] CART_FULL = CNT_W'(CART_DEPTH);

    state_e             state_q, state_d;
    logic [MONEY_W-1:0] in_q, in_d;
    logic [MONEY_W-1:0] need_q, need_d;
    logic [MONEY_W-1:0] chg_q, chg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MONEY_W-1:0] stack_q [CART_DEPTH];
    logic [MONEY_W-1:0] stack_d [CART_DEPTH];
    logic [4:0]         coin_out_q, coin_out_d;
    logic               err_q, err_d;

    // Only the highest-priority button of a simultaneous press is acted on.
    logic btn_cancel, btn_confirm, btn_goods, btn_change;
    assign btn_cancel  = bus.sys_Cancel;
    assign btn_confirm = bus.sys_Confirm & ~bus.sys_Cancel;
    assign btn_goods   = bus.sys_Goods & ~bus.sys_Confirm & ~bus.sys_Cancel;
    assign btn_change  = bus.sys_Change & ~bus.sys_Goods & ~bus.sys_Confirm & ~bus.sys_Cancel;

    // A dispense step happens on sys_Change, or every cycle in auto mode.
    logic disp_step;
`ifdef VEND_AUTO_CHANGE_EN
    assign disp_step = 1'b1;
`else
    assign disp_step = btn_change;
`endif

    logic [MONEY_W-1:0] item_price;
    assign item_price = MONEY_W'(unit_price(bus.type_SW_high, bus.type_SW_low)) * MONEY_W'(bus.num_SW);

    logic [5:0]         coin_val;
    logic [MONEY_W:0]   credit_sum;
    assign coin_val   = coin_value(bus.coin_in);
    assign credit_sum = {1'b0, in_q} + (MONEY_W + 1)'(coin_val);

    logic [4:0]         sel_coin;
    logic [MONEY_W-1:0] sel_val;

    vend_change_sel #(.MONEY_W(MONEY_W)) u_change_sel (
        .change_i (chg_q),
        .coin_o   (sel_coin),
        .value_o  (sel_val)
    );

    // Price of the most recently pushed item (top of the cart stack).
    logic [MONEY_W-1:0] top_price;
    always_comb begin
        top_price = '0;
        for (int i = 0; i < CART_DEPTH; i++) begin
            if (CNT_W'(i + 1) == cnt_q) top_price = stack_q[i];
        end
    end

    // Next-state and datapath updates; entering IDLE wipes the transaction.
    always_comb begin
        logic go_idle;
        go_idle    = 1'b0;
        state_d    = state_q;
        in_d       = in_q;
        need_d     = need_q;
        chg_d      = chg_q;
        cnt_d      = cnt_q;
        stack_d    = stack_q;
        coin_out_d = 5'b00000;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (btn_confirm) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (btn_cancel) begin
                    if (cnt_q != '0) begin
                        cnt_d  = cnt_q - CNT_W'(1);
                        need_d = need_q - top_price;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (btn_confirm) begin
                    if (cnt_q != '0) state_d = ST_PAYMENT;
                end else if (btn_goods && item_price != '0) begin
                    if (cnt_q == CART_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < CART_DEPTH; i++) begin
                            if (CNT_W'(i) == cnt_q) stack_d[i] = item_price;
                        end
                        cnt_d  = cnt_q + CNT_W'(1);
                        need_d = need_q + item_price;
                    end
                end
            end
            ST_PAYMENT: begin
                if (btn_cancel) begin
                    state_d = ST_REFUND;
                    chg_d   = in_q;
                    need_d  = '0;
                end else if (btn_confirm && in_q >= need_q) begin
                    state_d = ST_CHANGE;
                    chg_d   = in_q - need_q;
                end else if (coin_val != 6'd0) begin
                    if (credit_sum[MONEY_W]) begin
                        in_d  = '1;
                        err_d = 1'b1;
                    end else begin
                        in_d = credit_sum[MONEY_W-1:0];
                    end
                end
            end
            ST_CHANGE, ST_REFUND: begin
                if (disp_step) begin
                    if (chg_q != '0) begin
                        coin_out_d = sel_coin;
                        chg_d      = chg_q - sel_val;
                    end else begin
                        go_idle = 1'b1;
                    end
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (go_idle) begin
            state_d = ST_IDLE;
            in_d    = '0;
            need_d  = '0;
            chg_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            in_q       <= '0;
            need_q     <= '0;
            chg_q      <= '0;
            cnt_q      <= '0;
            coin_out_q <= 5'b00000;
            err_q      <= 1'b0;
            for (int i = 0; i < CART_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            in_q       <= in_d;
            need_q     <= need_d;
            chg_q      <= chg_d;
            cnt_q      <= cnt_d;
            coin_out_q <= coin_out_d;
            err_q      <= err_d;
            stack_q    <= stack_d;
        end
    end

    assign bus.input_money  = in_q;
    assign bus.need_money   = need_q;
    assign bus.change_money = chg_q;
    assign bus.state_out    = state_q;
    assign bus.cart_count   = cnt_q;
    assign bus.coin_out     = coin_out_q;
    assign bus.err_flag     = err_q;

endmodule

// File: tb/tb_vend_cart_ctrl.sv
// Self-checking bench for vend_cart_ctrl: directed scenarios followed by
// randomized button/coin traffic, compared against a transaction-level model.
module tb_vend_cart_ctrl;

    localparam int CART_DEPTH = 4;
    localparam int QTY_W      = 2;
    localparam int MONEY_W    = 10;
    localparam int MAX_MONEY  = (1 << MONEY_W) - 1;

    logic sys_clk;
    logic sys_rst_n;

    vend_cart_ctrl_if #(.CART_DEPTH(CART_DEPTH), .QTY_W(QTY_W), .MONEY_W(MONEY_W)) bus ();

    vend_cart_ctrl #(.CART_DEPTH(CART_DEPTH), .QTY_W(QTY_W), .MONEY_W(MONEY_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    // ---------------- clock ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 select, 2 payment, 3 change, 4 refund
    int m_mode;
    int m_in;
    int m_need;
    int m_chg;
    int m_coin;     // denomination paid out this cycle, 0 if none
    bit m_err;
    int m_cart[$];

    int price_tbl [16] = '{3, 4, 6, 3, 10, 8, 9, 7, 4, 6, 15, 8, 9, 4, 5, 5};

    int n_vec;
    int n_err;

    function automatic int price_ref(int hi, int lo);
        if (hi < 1 || hi > 4 || lo < 1 || lo > 4) return 0;
        return price_tbl[(hi - 1) * 4 + (lo - 1)];
    endfunction

    function automatic int coin_ref(logic [4:0] c);
        case (c)
            5'b00001: return 1;
            5'b00010: return 5;
            5'b00100: return 10;
            5'b01000: return 20;
            5'b10000: return 50;
            default:  return 0;
        endcase
    endfunction

    function automatic logic [4:0] denom_onehot(int d);
        case (d)
            1:  return 5'b00001;
            5:  return 5'b00010;
            10: return 5'b00100;
            20: return 5'b01000;
            50: return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic int cart_sum();
        int s;
        s = 0;
        foreach (m_cart[i]) s += m_cart[i];
        return s;
    endfunction

    function automatic void model_idle();
        m_mode = 0;
        m_in   = 0;
        m_need = 0;
        m_chg  = 0;
        m_err  = 1'b0;
        m_cart.delete();
    endfunction

    function automatic void model_step(bit g, bit cf, bit cn, bit ch, logic [4:0] coin,
                                       int hi, int lo, int num);
        int p;
        int v;
        bit step_now;
        m_coin = 0;
`ifdef VEND_AUTO_CHANGE_EN
        step_now = 1'b1;
`else
        step_now = ch && !cn && !cf && !g;
`endif
        case (m_mode)
            0: if (!cn && cf) m_mode = 1;
            1: begin
                if (cn) begin
                    if (m_cart.size() > 0) begin
                        void'(m_cart.pop_back());
                        m_need = cart_sum();
                    end else begin
                        model_idle();
                    end
                end else if (cf) begin
                    if (m_cart.size() > 0) m_mode = 2;
                end else if (g) begin
                    p = price_ref(hi, lo) * num;
                    if (p != 0) begin
                        if (m_cart.size() == CART_DEPTH) m_err = 1'b1;
                        else begin
                            m_cart.push_back(p);
                            m_need = cart_sum();
                        end
                    end
                end
            end
            2: begin
                if (cn) begin
                    m_mode = 4;
                    m_chg  = m_in;
                    m_need = 0;
                end else if (cf && m_in >= m_need) begin
                    m_mode = 3;
                    m_chg  = m_in - m_need;
                end else begin
                    v = coin_ref(coin);
                    if (v != 0) begin
                        if (m_in + v > MAX_MONEY) begin
                            m_in  = MAX_MONEY;
                            m_err = 1'b1;
                        end else begin
                            m_in = m_in + v;
                        end
                    end
                end
            end
            default: begin
                if (step_now) begin
                    if (m_chg > 0) begin
                        if (m_chg >= 50)      m_coin = 50;
                        else if (m_chg >= 20) m_coin = 20;
                        else if (m_chg >= 10) m_coin = 10;
                        else if (m_chg >= 5)  m_coin = 5;
                        else                  m_coin = 1;
                        m_chg = m_chg - m_coin;
                    end else begin
                        model_idle();
                    end
                end
            end
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("state_out",    bus.state_out,    32'(1 << m_mode));
        check_eq("input_money",  bus.input_money,  m_in);
        check_eq("need_money",   bus.need_money,   m_need);
        check_eq("change_money", bus.change_money, m_chg);
        check_eq("cart_count",   bus.cart_count,   m_cart.size());
        check_eq("coin_out",     bus.coin_out,     denom_onehot(m_coin));
        check_eq("err_flag",     bus.err_flag,     m_err);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit g, input bit cf, input bit cn, input bit ch,
                        input logic [4:0] coin, input int hi, input int lo, input int num);
        bus.sys_Goods    = g;
        bus.sys_Confirm  = cf;
        bus.sys_Cancel   = cn;
        bus.sys_Change   = ch;
        bus.coin_in      = coin;
        bus.type_SW_high = 3'(hi);
        bus.type_SW_low  = 3'(lo);
        bus.num_SW       = QTY_W'(num);
        @(posedge sys_clk);
        model_step(g, cf, cn, ch, coin, hi, lo, num);
        #1;
        bus.sys_Goods   = 1'b0;
        bus.sys_Confirm = 1'b0;
        bus.sys_Cancel  = 1'b0;
        bus.sys_Change  = 1'b0;
        bus.coin_in     = 5'b00000;
        check_outputs();
    endtask

    task automatic do_reset(input bit hold_change);
        sys_rst_n      = 1'b0;
        bus.sys_Change = hold_change;
        @(posedge sys_clk);
        model_idle();
        m_coin = 0;
        #1;
        sys_rst_n      = 1'b1;
        bus.sys_Change = 1'b0;
        check_outputs();
    endtask

    task automatic t_idle();               step(0, 0, 0, 0, 5'b0, 0, 0, 0);   endtask
    task automatic t_confirm();            step(0, 1, 0, 0, 5'b0, 0, 0, 0);   endtask
    task automatic t_cancel();             step(0, 0, 1, 0, 5'b0, 0, 0, 0);   endtask
    task automatic t_change();             step(0, 0, 0, 1, 5'b0, 0, 0, 0);   endtask
    task automatic t_coin(input logic [4:0] c); step(0, 0, 0, 0, c, 0, 0, 0); endtask
    task automatic t_goods(input int hi, input int lo, input int num);
        step(1, 0, 0, 0, 5'b0, hi, lo, num);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit g, cf, cn, ch;
        logic [4:0] coin;
        int r;
        n_vec = 0;
        n_err = 0;
        m_coin = 0;
        model_idle();
        sys_rst_n        = 1'b0;
        bus.sys_Goods    = 1'b0;
        bus.sys_Confirm  = 1'b0;
        bus.sys_Cancel   = 1'b0;
        bus.sys_Change   = 1'b0;
        bus.coin_in      = 5'b0;
        bus.type_SW_high = 3'd0;
        bus.type_SW_low  = 3'd0;
        bus.num_SW       = '0;

        do_reset(1'b0);
        check_eq("reset_state", bus.state_out, 32'h01);

        // Purchase of 0x13 x2 paid with 10+5, change 3 paid as 1,1,1.
        t_confirm();
        t_goods(1, 3, 2);
        check_eq("t1_need", bus.need_money, 12);
        t_confirm();
        t_coin(5'b00100);
        t_coin(5'b00010);
        check_eq("t1_in", bus.input_money, 15);
        t_confirm();
        check_eq("t1_chg", bus.change_money, 3);
        for (int i = 0; i < 3; i++) begin
            t_change();
            check_eq("t1_coin", bus.coin_out, 5'b00001);
            t_idle();
        end
        t_change();
        check_eq("t1_idle", bus.state_out, 32'h01);

        // Zero-price pushes ignored, then overfill the cart.
        t_confirm();
        t_goods(1, 5, 1);
        t_goods(1, 1, 0);
        check_eq("t2_empty", bus.cart_count, 0);
        for (int i = 0; i < 5; i++) t_goods(1, 1, 1);
        check_eq("t2_cnt", bus.cart_count, 4);
        check_eq("t2_err", bus.err_flag, 1);
        check_eq("t2_need", bus.need_money, 12);
        for (int i = 0; i < 5; i++) t_cancel();
        check_eq("t2_err_clr", bus.err_flag, 0);

        // Undo of the last item.
        t_confirm();
        t_goods(2, 1, 3);
        t_goods(3, 3, 1);
        check_eq("t3_need45", bus.need_money, 45);
        t_cancel();
        check_eq("t3_need", bus.need_money, 30);
        check_eq("t3_cnt", bus.cart_count, 1);

        // Refund of 50+20+1 in greedy order.
        t_confirm();
        t_coin(5'b10000);
        t_coin(5'b01000);
        t_coin(5'b00001);
        check_eq("t4_in", bus.input_money, 71);
        t_cancel();
        check_eq("t4_state", bus.state_out, 32'h10);
        check_eq("t4_chg", bus.change_money, 71);
        t_change(); check_eq("t4_c50", bus.coin_out, 5'b10000);
        t_change(); check_eq("t4_c20", bus.coin_out, 5'b01000);
        t_change(); check_eq("t4_c1",  bus.coin_out, 5'b00001);
        t_change(); check_eq("t4_idle", bus.state_out, 32'h01);

        // Multi-hot coin ignored; Confirm+Cancel resolves to Cancel.
        t_confirm();
        t_goods(4, 1, 1);
        t_confirm();
        t_coin(5'b00011);
        check_eq("t5_multihot", bus.input_money, 0);
        t_coin(5'b00100);
        step(0, 1, 1, 0, 5'b0, 0, 0, 0);
        check_eq("t5_refund", bus.state_out, 32'h10);
        t_change();
        t_idle();
        t_change();

        // Credit saturation, then reset while dispensing.
        t_confirm();
        t_goods(1, 1, 1);
        t_confirm();
        for (int i = 0; i < 21; i++) t_coin(5'b10000);
        check_eq("t6_sat", bus.input_money, MAX_MONEY);
        check_eq("t6_err", bus.err_flag, 1);
        t_confirm();
        check_eq("t6_chg", bus.change_money, MAX_MONEY - 3);
        t_change();
        do_reset(1'b1);
        check_eq("t7_state", bus.state_out, 32'h01);
        check_eq("t7_coin", bus.coin_out, 0);
        t_idle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                g  = ($urandom_range(0, 3) == 0);
                cf = ($urandom_range(0, 4) == 0);
                cn = ($urandom_range(0, 9) == 0);
                ch = ($urandom_range(0, 2) == 0);
                r  = $urandom_range(0, 9);
                if (r < 6)       coin = 5'(1 << $urandom_range(0, 4));
                else if (r == 6) coin = 5'(($urandom_range(1, 31)));
                else             coin = 5'b00000;
                step(g, cf, cn, ch, coin, $urandom_range(0, 5), $urandom_range(0, 5),
                     $urandom_range(0, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
